// File: rtl/mipi_capture_pkg.sv
// Shared types and constants for the MIPI RX capture front-end.
package mipi_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    LINE,
    FLUSH
  } cap_state_t;

  localparam logic [31:0] HDR_MAGIC = 32'hF5A5_0000;
  localparam logic [3:0]  CNT_MAX   = 4'd8;

  // Byte counts above one full beat are treated as a full beat.
  function automatic logic [3:0] clamp_cnt(input logic [3:0] cnt);
    return (cnt > CNT_MAX) ? CNT_MAX : cnt;
  endfunction

  function automatic logic [63:0] header_word(input logic [15:0] frame_num);
    return {HDR_MAGIC, 16'h0000, frame_num};
  endfunction

endpackage

// File: rtl/mipi_rx_capture_byte_packer.sv
// Packs variable-width byte beats into dense 64-bit words; flush drains a partial word.
module byte_packer
  import mipi_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_valid,
  input  logic [63:0] beat,
  input  logic [3:0]  cnt,
  input  logic        flush,
  output logic [63:0] word,
  output logic        emit
);

  logic [63:0]  acc_q;
  logic [2:0]   fill_q;
  logic [63:0]  acc_d;
  logic [2:0]   fill_d;
  logic [3:0]   cnt_c;
  logic [63:0]  beat_m;
  logic [127:0] merged;
  logic [3:0]   sum;

  // Bytes of acc_q at or above fill_q are always zero, so OR-merging is safe.
  always_comb begin
    cnt_c  = clamp_cnt(cnt);
    beat_m = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(cnt_c)) beat_m[8*k +: 8] = beat[8*k +: 8];
    end
    merged = {64'h0, acc_q} | ({64'h0, beat_m} << {fill_q, 3'b000});
    sum    = {1'b0, fill_q} + cnt_c;

    word   = '0;
    emit   = 1'b0;
    acc_d  = acc_q;
    fill_d = fill_q;

    if (flush) begin
      if (fill_q != 3'd0) begin
        word = acc_q;
        emit = 1'b1;
      end
      acc_d  = '0;
      fill_d = '0;
    end else if (beat_valid) begin
      fill_d = sum[2:0];
      if (sum[3]) begin
        word  = merged[63:0];
        emit  = 1'b1;
        acc_d = merged[127:64];
      end else begin
        acc_d = merged[63:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/mipi_rx_capture.sv
// MIPI RX capture: VC filter, frame/line FSM, byte packing and FIFO-full drop accounting.
// Define MIPI_CAPTURE_HEADER_EN to emit a header word at the start of every frame.
module mipi_rx_capture
  import mipi_capture_pkg::*;
#(
  parameter int VC_SEL = 0,
  parameter int CNT_W  = 16
) (
  input  logic             rx_pixel_clk,
  input  logic             rst,
  input  logic             mipi_valid,
  input  logic [3:0]       mipi_hsync,
  input  logic [3:0]       mipi_vsync,
  input  logic [63:0]      mipi_data,
  input  logic [3:0]       mipi_cnt,
  input  logic [1:0]       mipi_vc,
  input  logic             fifo_full,
  output logic [63:0]      fifo_data,
  output logic             fifo_we,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0]       VC_ID   = 2'(VC_SEL);
  localparam int               DW      = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cap_state_t  state;
  logic        vs, hs, vs_q, hs_q;
  logic        vs_rise, vs_fall, hs_rise, hs_fall;
  logic        end_pending;
  logic        accept, pk_beat, pk_flush, pk_emit;
  logic [63:0] pk_word;
  logic        hdr_emit;
  logic [63:0] hdr_word;
  logic        emit_any, emit_ok;
  logic [63:0] emit_word;
  logic [1:0]  drop_inc;
  logic [DW-1:0] drop_sum;

  assign vs      = mipi_vsync[VC_SEL];
  assign hs      = mipi_hsync[VC_SEL];
  assign vs_rise = vs & ~vs_q;
  assign vs_fall = ~vs & vs_q;
  assign hs_rise = hs & ~hs_q;
  assign hs_fall = ~hs & hs_q;

  assign accept   = mipi_valid && (mipi_vc == VC_ID);
  assign pk_beat  = accept && (state == LINE);
  assign pk_flush = (state == FLUSH);

`ifdef MIPI_CAPTURE_HEADER_EN
  logic [15:0] frame16;
  if (CNT_W >= 16) begin : g_fc_trunc
    assign frame16 = frame_cnt[15:0];
  end else begin : g_fc_ext
    assign frame16 = {{(16-CNT_W){1'b0}}, frame_cnt};
  end
  assign hdr_emit = (state == IDLE) && vs_rise;
  assign hdr_word = header_word(frame16);
`else
  assign hdr_emit = 1'b0;
  assign hdr_word = '0;
`endif

  byte_packer u_packer (
    .clk        (rx_pixel_clk),
    .rst        (rst),
    .beat_valid (pk_beat),
    .beat       (mipi_data),
    .cnt        (mipi_cnt),
    .flush      (pk_flush),
    .word       (pk_word),
    .emit       (pk_emit)
  );

  // Header and packer emits never coincide: one needs IDLE, the other LINE/FLUSH.
  assign emit_any  = pk_emit | hdr_emit;
  assign emit_ok   = emit_any & ~fifo_full;
  assign emit_word = hdr_emit ? hdr_word : pk_word;
  assign drop_inc  = {1'b0, emit_any & fifo_full} + {1'b0, accept & (state != LINE)};
  assign drop_sum  = {1'b0, drop_cnt} + DW'(drop_inc);

  // Sync levels reset high so a frame already running at reset release is skipped.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state       <= IDLE;
      vs_q        <= 1'b1;
      hs_q        <= 1'b1;
      end_pending <= 1'b0;
      frame_cnt   <= '0;
      line_cnt    <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      fifo_we     <= 1'b0;
      fifo_data   <= '0;
    end else begin
      vs_q    <= vs;
      hs_q    <= hs;
      fifo_we <= emit_ok;
      if (emit_ok) fifo_data <= emit_word;
      if (drop_inc != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end

      case (state)
        IDLE: begin
          if (vs_rise) begin
            state    <= FRAME;
            line_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        FRAME: begin
          if (vs_fall) begin
            state     <= IDLE;
            frame_cnt <= frame_cnt + CNT_ONE;
            busy      <= 1'b0;
          end else if (hs_rise) begin
            state <= LINE;
          end
        end
        LINE: begin
          if (hs_fall || vs_fall) begin
            state       <= FLUSH;
            end_pending <= vs_fall;
          end
        end
        FLUSH: begin
          line_cnt    <= line_cnt + CNT_ONE;
          end_pending <= 1'b0;
          if (end_pending || vs_fall) begin
            state     <= IDLE;
            frame_cnt <= frame_cnt + CNT_ONE;
            busy      <= 1'b0;
          end else begin
            state <= FRAME;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
